// File: rtl/waveform_buffer.sv
// Waveform table loader and sample server for the autoapproach engine.
// Optional load checksum output enabled by defining WAVEFORM_BUFFER_CHECKSUM_EN.
module waveform_buffer #(
  parameter int WORD_WID      = 24,
  parameter int WORD_AMNT_WID = 11,
  parameter int WORD_AMNT     = 2047,
  parameter int RAM_WID       = 32,
  parameter int RAM_WORD_WID  = 16,
  parameter int RAM_WORD_INCR = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    refresh_start,
  input  logic [RAM_WID-1:0]      start_addr,
  output logic                    refresh_finished,
  output logic [RAM_WID-1:0]      ram_dma_addr,
  input  logic [RAM_WORD_WID-1:0] ram_word,
  output logic                    ram_read,
  input  logic                    ram_valid,
  output logic [WORD_WID-1:0]     word,
  input  logic                    word_next,
  output logic                    word_ok,
  output logic                    word_last,
`ifdef WAVEFORM_BUFFER_CHECKSUM_EN
  input  logic                    word_rst,
  output logic [WORD_WID-1:0]     load_checksum
`else
  input  logic                    word_rst
`endif
);

  localparam int HI_KEEP = WORD_WID - RAM_WORD_WID;
  localparam logic [WORD_AMNT_WID-1:0] LAST_IDX  = WORD_AMNT_WID'(WORD_AMNT);
  localparam logic [WORD_AMNT_WID-1:0] PTR_ONE   = WORD_AMNT_WID'(1);
  localparam logic [RAM_WID-1:0]       ADDR_INCR = RAM_WID'(RAM_WORD_INCR);

  typedef enum logic [2:0] {
    L_IDLE    = 3'd0,
    L_REQ_LO  = 3'd1,
    L_WAIT_LO = 3'd2,
    L_REQ_HI  = 3'd3,
    L_WAIT_HI = 3'd4,
    L_WRITE   = 3'd5,
    L_DONE    = 3'd6
  } load_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_HOLD  = 2'd2
  } read_state_t;

  load_state_t load_state_r, load_state_s;
  read_state_t read_state_r, read_state_s;

  logic [RAM_WID-1:0]       addr_r, addr_s;
  logic [RAM_WORD_WID-1:0]  lo_r, lo_s;
  logic [HI_KEEP-1:0]       hi_r, hi_s;
  logic [WORD_AMNT_WID-1:0] wr_ptr_r, wr_ptr_s;
  logic                     table_loaded_r, table_loaded_s;
  logic                     refresh_finished_s;
  logic                     ram_read_s;
  logic [RAM_WID-1:0]       ram_dma_addr_s;
  logic [WORD_WID-1:0]      sample_s;
  logic                     wr_en_s;

  logic [WORD_AMNT_WID-1:0] rd_ptr_r, rd_ptr_s;
  logic [WORD_WID-1:0]      rd_data_r;
  logic [WORD_WID-1:0]      word_s;
  logic                     word_ok_s;
  logic                     word_last_s;
  logic                     load_quiet_s;

  logic [WORD_WID-1:0]      mem_r [0:WORD_AMNT];

  assign sample_s     = {hi_r, lo_r};
  assign wr_en_s      = (load_state_r == L_WRITE);
  assign load_quiet_s = (load_state_r == L_IDLE) || (load_state_r == L_DONE);

  // Load FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_state_r <= L_IDLE;
    end else begin
      load_state_r <= load_state_s;
    end
  end

  // Load FSM next-state logic
  always_comb begin
    load_state_s = load_state_r;
    case (load_state_r)
      L_IDLE:    if (refresh_start) load_state_s = L_REQ_LO; else load_state_s = L_IDLE;
      L_REQ_LO:  load_state_s = L_WAIT_LO;
      L_WAIT_LO: if (ram_valid) load_state_s = L_REQ_HI; else load_state_s = L_WAIT_LO;
      L_REQ_HI:  load_state_s = L_WAIT_HI;
      L_WAIT_HI: if (ram_valid) load_state_s = L_WRITE; else load_state_s = L_WAIT_HI;
      L_WRITE:   if (wr_ptr_r == LAST_IDX) load_state_s = L_DONE; else load_state_s = L_REQ_LO;
      L_DONE:    if (!refresh_start) load_state_s = L_IDLE; else load_state_s = L_DONE;
      default:   load_state_s = L_IDLE;
    endcase
  end

  // Load FSM output logic: next values of the DMA outputs and load datapath
  always_comb begin
    addr_s             = addr_r;
    lo_s               = lo_r;
    hi_s               = hi_r;
    wr_ptr_s           = wr_ptr_r;
    table_loaded_s     = table_loaded_r;
    refresh_finished_s = refresh_finished;
    ram_read_s         = ram_read;
    ram_dma_addr_s     = ram_dma_addr;
    case (load_state_r)
      L_IDLE: begin
        if (refresh_start) begin
          addr_s         = start_addr;
          wr_ptr_s       = {WORD_AMNT_WID{1'b0}};
          table_loaded_s = 1'b0;
        end else begin
          table_loaded_s = table_loaded_r;
        end
      end
      L_REQ_LO, L_REQ_HI: begin
        ram_dma_addr_s = addr_r;
        ram_read_s     = 1'b1;
      end
      L_WAIT_LO: begin
        if (ram_valid) begin
          lo_s       = ram_word;
          ram_read_s = 1'b0;
          addr_s     = addr_r + ADDR_INCR;
        end else begin
          ram_read_s = 1'b1;
        end
      end
      L_WAIT_HI: begin
        if (ram_valid) begin
          hi_s       = ram_word[HI_KEEP-1:0];
          ram_read_s = 1'b0;
          addr_s     = addr_r + ADDR_INCR;
        end else begin
          ram_read_s = 1'b1;
        end
      end
      L_WRITE: begin
        if (wr_ptr_r == LAST_IDX) begin
          refresh_finished_s = 1'b1;
          table_loaded_s     = 1'b1;
        end else begin
          wr_ptr_s = wr_ptr_r + PTR_ONE;
        end
      end
      L_DONE: begin
        if (!refresh_start) begin
          refresh_finished_s = 1'b0;
        end else begin
          refresh_finished_s = 1'b1;
        end
      end
      default: begin
        ram_read_s = 1'b0;
      end
    endcase
  end

  // Load datapath and DMA output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r           <= {RAM_WID{1'b0}};
      lo_r             <= {RAM_WORD_WID{1'b0}};
      hi_r             <= {HI_KEEP{1'b0}};
      wr_ptr_r         <= {WORD_AMNT_WID{1'b0}};
      table_loaded_r   <= 1'b0;
      refresh_finished <= 1'b0;
      ram_read         <= 1'b0;
      ram_dma_addr     <= {RAM_WID{1'b0}};
    end else begin
      addr_r           <= addr_s;
      lo_r             <= lo_s;
      hi_r             <= hi_s;
      wr_ptr_r         <= wr_ptr_s;
      table_loaded_r   <= table_loaded_s;
      refresh_finished <= refresh_finished_s;
      ram_read         <= ram_read_s;
      ram_dma_addr     <= ram_dma_addr_s;
    end
  end

  // Block RAM: one write port for the loader, registered read port for the reader
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= sample_s;
    end
    rd_data_r <= mem_r[rd_ptr_r];
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_state_r <= R_IDLE;
    end else begin
      read_state_r <= read_state_s;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    read_state_s = read_state_r;
    case (read_state_r)
      R_IDLE: begin
        if (word_rst) begin
          read_state_s = R_IDLE;
        end else if (word_next && table_loaded_r && load_quiet_s) begin
          read_state_s = R_FETCH;
        end else begin
          read_state_s = R_IDLE;
        end
      end
      R_FETCH: read_state_s = R_HOLD;
      R_HOLD:  if (!word_next) read_state_s = R_IDLE; else read_state_s = R_HOLD;
      default: read_state_s = R_IDLE;
    endcase
  end

  // Read FSM output logic: next values of the sample outputs and read pointer
  always_comb begin
    rd_ptr_s    = rd_ptr_r;
    word_s      = word;
    word_ok_s   = word_ok;
    word_last_s = word_last;
    case (read_state_r)
      R_IDLE: begin
        if (word_rst) begin
          rd_ptr_s  = {WORD_AMNT_WID{1'b0}};
          word_ok_s = 1'b0;
        end else begin
          word_ok_s = 1'b0;
        end
      end
      R_FETCH: begin
        word_s      = rd_data_r;
        word_last_s = (rd_ptr_r == LAST_IDX);
        word_ok_s   = 1'b1;
      end
      R_HOLD: begin
        if (!word_next) begin
          word_ok_s   = 1'b0;
          word_last_s = 1'b0;
          if (rd_ptr_r == LAST_IDX) begin
            rd_ptr_s = {WORD_AMNT_WID{1'b0}};
          end else begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
          end
        end else begin
          word_ok_s = 1'b1;
        end
      end
      default: begin
        word_ok_s   = 1'b0;
        word_last_s = 1'b0;
      end
    endcase
  end

  // Read pointer and sample output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r  <= {WORD_AMNT_WID{1'b0}};
      word      <= {WORD_WID{1'b0}};
      word_ok   <= 1'b0;
      word_last <= 1'b0;
    end else begin
      rd_ptr_r  <= rd_ptr_s;
      word      <= word_s;
      word_ok   <= word_ok_s;
      word_last <= word_last_s;
    end
  end

`ifdef WAVEFORM_BUFFER_CHECKSUM_EN
  // Running modular sum of every sample written during the current load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_checksum <= {WORD_WID{1'b0}};
    end else if ((load_state_r == L_IDLE) && refresh_start) begin
      load_checksum <= {WORD_WID{1'b0}};
    end else if (wr_en_s) begin
      load_checksum <= load_checksum + sample_s;
    end
  end
`else
`endif

endmodule

// File: tb/tb_waveform_buffer.sv
// Directed bench for waveform_buffer with a 4-entry table, a DMA responder
// and scoreboards for DMA addresses and served samples.
module tb_waveform_buffer;
  localparam int WW  = 24;
  localparam int AW  = 2;
  localparam int RW  = 32;
  localparam int RWW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           refresh_start = 1'b0;
  logic [RW-1:0]  start_addr = 32'h0;
  logic           refresh_finished;
  logic [RW-1:0]  ram_dma_addr;
  logic [RWW-1:0] ram_word = 16'h0;
  logic           ram_read;
  logic           ram_valid = 1'b0;
  logic [WW-1:0]  word;
  logic           word_next = 1'b0;
  logic           word_ok;
  logic           word_last;
  logic           word_rst = 1'b0;
`ifdef WAVEFORM_BUFFER_CHECKSUM_EN
  logic [WW-1:0]  load_checksum;
`endif

  int checks = 0;
  int failures = 0;
  int reads = 0;
  logic [RW-1:0] addr_exp_q[$];
  logic [WW:0]   word_exp_q[$];
  logic [15:0]   ram_mem [0:511];
  logic [WW-1:0] exp_sample [0:3];
  logic          prev_ok = 1'b0;

  always #5 clk = ~clk;

  waveform_buffer #(
    .WORD_WID(WW), .WORD_AMNT_WID(AW), .WORD_AMNT(3),
    .RAM_WID(RW), .RAM_WORD_WID(RWW), .RAM_WORD_INCR(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .refresh_start(refresh_start), .start_addr(start_addr),
    .refresh_finished(refresh_finished), .ram_dma_addr(ram_dma_addr), .ram_word(ram_word),
    .ram_read(ram_read), .ram_valid(ram_valid), .word(word), .word_next(word_next),
    .word_ok(word_ok), .word_last(word_last),
`ifdef WAVEFORM_BUFFER_CHECKSUM_EN
    .word_rst(word_rst), .load_checksum(load_checksum)
`else
    .word_rst(word_rst)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DMA responder: answers each read 3 cycles later and checks the address order
  initial begin
    forever begin
      @(posedge clk);
      if (ram_read === 1'b1) begin
        reads++;
        check("dma_read_expected", 32'(addr_exp_q.size() != 0), 32'd1);
        if (addr_exp_q.size() != 0) check("dma_addr", ram_dma_addr, addr_exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        ram_word  = ram_mem[ram_dma_addr[9:1]];
        ram_valid = 1'b1;
        @(posedge clk);
        #1 ram_valid = 1'b0;
      end
    end
  end

  // Sample scoreboard: compares each word_ok rise against the next expected sample
  always @(negedge clk) begin
    if (word_ok === 1'b1 && prev_ok !== 1'b1) begin
      check("word_expected", 32'(word_exp_q.size() != 0), 32'd1);
      if (word_exp_q.size() != 0) begin
        logic [WW:0] e;
        e = word_exp_q.pop_front();
        check("word", 32'(word), 32'(e[WW-1:0]));
        check("word_last", 32'(word_last), 32'(e[WW]));
      end
    end
    prev_ok <= word_ok;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_load(input logic [31:0] base);
    start_addr = base;
    for (int i = 0; i < 8; i++) addr_exp_q.push_back(base + 32'(2 * i));
    refresh_start = 1'b1;
  endtask

  task automatic wait_finished();
    int n = 0;
    while (refresh_finished !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_done", 32'(refresh_finished), 32'd1);
  endtask

  // One word_next pulse; starts and ends on a falling edge with the reader idle
  task automatic read_word(input logic [WW-1:0] s, input logic last);
    word_exp_q.push_back({last, s});
    word_next = 1'b1;
    @(negedge clk);
    check("lat1_ok", 32'(word_ok), 32'd0);
    @(negedge clk);
    check("lat2_ok", 32'(word_ok), 32'd1);
    word_next = 1'b0;
    @(negedge clk);
    check("drop_ok", 32'(word_ok), 32'd0);
    check("drop_last", 32'(word_last), 32'd0);
  endtask

  initial begin
    int r0;
    int n;
    exp_sample[0] = 24'hAA1111;
    exp_sample[1] = 24'hBB2222;
    exp_sample[2] = 24'hCC3333;
    exp_sample[3] = 24'hDD4444;
    for (int i = 0; i < 512; i++) ram_mem[i] = 16'h0;
    for (int i = 0; i < 4; i++) begin
      ram_mem[9'h080 + 9'(2 * i)]     = 16'h1111 * 16'(i + 1);
      ram_mem[9'h080 + 9'(2 * i + 1)] = 16'h00AA + 16'h0011 * 16'(i);
    end
    ram_mem[9'h180] = 16'h0001; ram_mem[9'h181] = 16'hAB00;
    ram_mem[9'h182] = 16'h0002; ram_mem[9'h183] = 16'h0000;
    ram_mem[9'h184] = 16'h0003; ram_mem[9'h185] = 16'h0000;
    ram_mem[9'h186] = 16'hFFFF; ram_mem[9'h187] = 16'h12FF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_finished", 32'(refresh_finished), 32'd0);
    check("rst_ram_read", 32'(ram_read), 32'd0);
    check("rst_dma_addr", ram_dma_addr, 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_ok", 32'(word_ok), 32'd0);
    check("rst_word_last", 32'(word_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // No table yet: word_next stalls, then served 2 cycles after the load completes
    word_exp_q.push_back({1'b0, exp_sample[0]});
    word_next = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_no_table", 32'(word_ok), 32'd0);
    r0 = reads;
    start_load(32'h100);
    wait_finished();
    check("read_count", 32'(reads - r0), 32'd8);
    @(negedge clk);
    check("post_done_1", 32'(word_ok), 32'd0);
    @(negedge clk);
    check("post_done_2", 32'(word_ok), 32'd1);
    word_next = 1'b0;
    refresh_start = 1'b0;
    @(negedge clk);
    check("finished_clear", 32'(refresh_finished), 32'd0);

    // Remaining samples, last flag, then wrap to sample 0
    read_word(exp_sample[1], 1'b0);
    read_word(exp_sample[2], 1'b0);
    read_word(exp_sample[3], 1'b1);
    read_word(exp_sample[0], 1'b0);

    // Rewind after sample 1
    read_word(exp_sample[1], 1'b0);
    word_rst = 1'b1;
    @(negedge clk);
    word_rst = 1'b0;
    read_word(exp_sample[0], 1'b0);

    // Async reset while the high half is outstanding
    start_load(32'h100);
    n = 0;
    while (!(ram_read === 1'b1 && ram_dma_addr === 32'h102) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait_hi", ram_dma_addr, 32'h102);
    rst_n = 1'b0;
    #1;
    check("arst_ram_read", 32'(ram_read), 32'd0);
    check("arst_dma_addr", ram_dma_addr, 32'd0);
    check("arst_word", 32'(word), 32'd0);
    check("arst_finished", 32'(refresh_finished), 32'd0);
    addr_exp_q.delete();
    refresh_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    word_exp_q.push_back({1'b0, exp_sample[0]});
    word_next = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_after_rst", 32'(word_ok), 32'd0);
    start_load(32'h100);
    wait_finished();
    @(negedge clk);
    check("reload_1", 32'(word_ok), 32'd0);
    @(negedge clk);
    check("reload_2", 32'(word_ok), 32'd1);
    word_next = 1'b0;
    refresh_start = 1'b0;
    @(negedge clk);

`ifdef WAVEFORM_BUFFER_CHECKSUM_EN
    start_load(32'h300);
    wait_finished();
    check("checksum", 32'(load_checksum), 32'h000005);
    refresh_start = 1'b0;
    @(negedge clk);
`endif

    repeat (6) @(negedge clk);
    check("addr_q_drained", 32'(addr_exp_q.size()), 32'd0);
    check("word_q_drained", 32'(word_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
